// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int START_MID  = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on rdata
// whenever the FIFO is not empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling, feeding a FWFT byte FIFO that is
// drained through a valid/ready handshake.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 54,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        RX,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] rx_level
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  rx_state_t            state, state_nx;
  logic                 rx_meta, rx_s;
  logic [BW-1:0]        baud_cnt, baud_cnt_nx;
  logic [3:0]           os_cnt, os_cnt_nx;
  logic [2:0]           bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 armed, armed_nx;
  logic                 push_pending, push_nx;
  logic                 fe_nx;
  logic                 tick;
  logic                 fifo_full, fifo_empty;

  assign tick     = (state != IDLE) && (baud_cnt == BW'(BAUD_DIV - 1));
  assign rx_valid = ~fifo_empty;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      os_cnt       <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      armed        <= 1'b0;
      push_pending <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nx;
      baud_cnt     <= baud_cnt_nx;
      os_cnt       <= os_cnt_nx;
      bit_idx      <= bit_idx_nx;
      shreg        <= shreg_nx;
      armed        <= armed_nx;
      push_pending <= push_nx;
      frame_err    <= fe_nx;
      overrun      <= push_pending & fifo_full & ~(rx_valid & rx_ready);
    end
  end

  // Baud counter idles at zero so the first tick lands BAUD_DIV clocks after start detect.
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = '0;
    os_cnt_nx   = os_cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    armed_nx    = armed;
    push_nx     = 1'b0;
    fe_nx       = 1'b0;

    if (state != IDLE) baud_cnt_nx = tick ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE: begin
        os_cnt_nx = '0;
        if (armed && !rx_s) state_nx = START;
        else                armed_nx = armed | rx_s;
      end
      START: begin
        if (tick) begin
          if (os_cnt == 4'(START_MID - 1)) begin
            os_cnt_nx = '0;
            if (rx_s) begin
              state_nx = IDLE;
              armed_nx = 1'b1;
            end else begin
              state_nx   = DATA;
              bit_idx_nx = '0;
            end
          end else begin
            os_cnt_nx = os_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == 4'(OVERSAMPLE - 1)) begin
            os_cnt_nx         = '0;
            shreg_nx[bit_idx] = rx_s;
            if (bit_idx == 3'(DATA_BITS - 1)) state_nx = STOP;
            else                              bit_idx_nx = bit_idx + 3'd1;
          end else begin
            os_cnt_nx = os_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        // A low stop bit leaves IDLE disarmed so a held-low line cannot retrigger.
        if (tick) begin
          if (os_cnt == 4'(OVERSAMPLE - 1)) begin
            os_cnt_nx = '0;
            state_nx  = IDLE;
            armed_nx  = rx_s;
            push_nx   = rx_s;
            fe_nx     = ~rx_s;
          end else begin
            os_cnt_nx = os_cnt + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RESETN),
    .push (push_pending),
    .wdata(shreg),
    .pop  (rx_ready),
    .rdata(rx_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(rx_level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven serially, expected bytes
// are queued at send time and a negedge monitor checks every handshake pop.
module tb_uart_rx_fifo;

  localparam int BD    = 12;
  localparam int DEPTH = 8;
  localparam int BIT   = 16 * BD;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [3:0] rx_level;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       fe_prev = 1'b0;
  logic       ov_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  uart_rx_fifo #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .RX       (RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_level (rx_level)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every accepted pop must match the oldest queued byte.
  always @(negedge CLK) begin
    if (RESETN && rx_valid && rx_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL pop_unexpected: got 0x%02h, required no byte", rx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        if (rx_data !== exp_byte) begin
          mismatched++;
          $display("[TB] FAIL pop_data: got 0x%02h, required 0x%02h", rx_data, exp_byte);
        end
      end
    end
    if (frame_err === 1'b1) begin
      fe_cnt++;
      compared++;
      if (fe_prev) begin
        mismatched++;
        $display("[TB] FAIL fe_width: frame_err high 2 cycles, required 1");
      end
    end
    if (overrun === 1'b1) begin
      ov_cnt++;
      compared++;
      if (ov_prev) begin
        mismatched++;
        $display("[TB] FAIL ov_width: overrun high 2 cycles, required 1");
      end
    end
    fe_prev = (frame_err === 1'b1);
    ov_prev = (overrun === 1'b1);
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  // Called and returns at posedge+1 so every bit lasts exactly BIT clocks.
  task automatic driveBit(input logic b);
    RX = b;
    repeat (BIT) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop, input bit expect_push);
    if (expect_push) exp_q.push_back(data);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stop);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CLK);
    checkOutput("drain_left", exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, int'(rx_valid), 0);
    checkOutput({tag, "_data"}, int'(rx_data), 0);
    checkOutput({tag, "_fe"}, int'(frame_err), 0);
    checkOutput({tag, "_ov"}, int'(overrun), 0);
    checkOutput({tag, "_level"}, int'(rx_level), 0);
  endtask

  initial begin
    int fall_cyc;
    int rise_cyc;
    int fe0;
    int ov0;
    logic [7:0] brk;

    repeat (3) @(posedge CLK);
    #1;
    checkResetValues("reset");
    RESETN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Single frame with latency measurement from RX fall to rx_valid.
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rise_cyc = -1;
    fall_cyc = cyc;
    fork
      applyStimulus(8'hA5, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 4 + 152 * BD + 100; i++) begin
          @(negedge CLK);
          if (rx_valid) begin
            rise_cyc = cyc;
            break;
          end
        end
        checkOutput("latency", rise_cyc - fall_cyc, 4 + 152 * BD);
        checkOutput("level_one", int'(rx_level), 1);
        checkOutput("head_a5", int'(rx_data), 'hA5);
        @(negedge CLK);
        checkOutput("level_zero", int'(rx_level), 0);
      end
    join
    waitDrain(100);

    // Back-to-back frames with no idle gap.
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'h55, 1'b1, 1'b1);
    waitDrain(100);
    checkOutput("b2b_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Short low glitch shorter than half a bit.
    RX = 1'b0;
    repeat (4 * BD) @(posedge CLK);
    #1;
    RX = 1'b1;
    repeat (12 * BIT) @(posedge CLK);
    #1;
    checkOutput("glitch_level", int'(rx_level), 0);
    checkOutput("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Framing error with the line held low past the stop bit.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput("fe_count", fe_cnt - fe0, 1);
    checkOutput("fe_level", int'(rx_level), 0);
    applyStimulus(8'h12, 1'b1, 1'b1);
    waitDrain(100);
    checkOutput("fe_after_12", fe_cnt - fe0, 1);

    // Overrun: nine frames into an eight-entry FIFO with no consumer.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b1, (i <= 8));
    checkOutput("ov_level", int'(rx_level), 8);
    checkOutput("ov_count", ov_cnt - ov0, 1);
    checkOutput("ov_head", int'(rx_data), 'h01);
    rx_ready = 1'b1;
    waitDrain(200);
    checkOutput("ov_drained", int'(rx_level), 0);

    // Reset during data bit 3 with one byte parked in the FIFO.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    applyStimulus(8'h77, 1'b1, 1'b0);
    driveBit(1'b1);
    checkOutput("park_level", int'(rx_level), 1);
    checkOutput("park_head", int'(rx_data), 'h77);
    brk = 8'hFA;
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(brk[i]);
    RX = brk[3];
    repeat (BIT / 2) @(posedge CLK);
    #1;
    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkResetValues("midrst");
    RESETN = 1'b1;
    repeat (BIT / 2 - 3) @(posedge CLK);
    #1;
    for (int i = 4; i < 8; i++) driveBit(brk[i]);
    driveBit(1'b1);
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput("rst_no_push", int'(rx_level), 0);
    rx_ready = 1'b1;
    applyStimulus(8'hC3, 1'b1, 1'b1);
    waitDrain(100);
    checkOutput("rst_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    checkOutput("sb_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    mismatched++;
    $display("[TB] FAIL watchdog: run exceeded time limit, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive path for the T20 RISC-V lite SoC. Samples the asynchronous `RX` pin in the 100 MHz PLL `CLKOUT0` domain using 16x oversampling and decodes 8N1 frames, LSB first. Buffers received bytes in a small first-word-fall-through FIFO and presents them to the core's UART register block through a valid/ready handshake. It is the receiving counterpart of the core's transmit path that drives `TX`.

## Interface
- `BAUD_DIV`, 54: clocks per oversample tick; 100 MHz / (115200 × 16) ≈ 54.
- `FIFO_DEPTH`, 8: byte entries; must be a power of two, at least 2.
- `CLK` in 1: PLL `CLKOUT0`, 100 MHz; the only clock.
- `RESETN` in 1: asynchronous, active-low reset.
- `RX` in 1: raw serial input pin; asynchronous; idles high.
- `rx_data` out 8: byte at the FIFO head; valid only while `rx_valid` is 1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer pops the head when `rx_valid & rx_ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit samples 0.
- `overrun` out 1: one-cycle pulse when a good byte arrives with the FIFO full.
- `rx_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Synchronizer: a 2-FF chain on `RX` produces `rx_s`. Both flops reset to 1.
- Tick generator: counts 0..BAUD_DIV-1 and emits `tick` at BAUD_DIV-1. It is held at 0 in IDLE and restarts from 0 on start detect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: becomes armed once `rx_s` has been 1 for at least one cycle. When armed and `rx_s`=0, go to START and clear the oversample counter.
  - START: after 8 ticks (mid start bit), if `rx_s`=0 go to DATA with bit index 0. If `rx_s`=1 it was a glitch: go to IDLE with no flag.
  - DATA: every 16 ticks, shift `rx_s` into bit[index], LSB first. After index 7 go to STOP.
  - STOP: sample after 16 ticks.
    - `rx_s`=1 and FIFO not full: push the byte.
    - `rx_s`=1 and FIFO full: pulse `overrun` and drop the new byte. FIFO contents are unchanged.
    - `rx_s`=0: pulse `frame_err` and discard the byte. Go to IDLE disarmed, so a break or low line does not retrigger until `rx_s` returns to 1.
  - From STOP (good byte), return to IDLE immediately at the mid-stop sample. IDLE is armed because `rx_s`=1, which allows back-to-back frames.
- FIFO behaviour:
  - Push and pop in the same cycle: both happen and the level is unchanged.
  - FIFO full: a push is accepted in a cycle that also pops.
  - FIFO empty: a pop is ignored.
- Pointer arithmetic: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; the level is one bit wider.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0, `rx_level`=0.
  - FSM in IDLE, disarmed; the synchronizer holds 1s.
- Assertion of `RESETN` mid-frame aborts the frame and empties the FIFO. No flags are emitted.
- Input latency: 2 cycles from `RX` to `rx_s`.
- Start detect: the FSM enters START on the cycle after `rx_s` falls.
- Byte latency: the FIFO write happens at the mid-stop sample, (8+16×9)×BAUD_DIV clocks after START entry. `rx_valid` rises the next cycle when the FIFO was empty.
- Read path:
  - `rx_data` is combinational from FIFO storage (FWFT) and changes the cycle after a pop.
  - The pop is registered, and `rx_level` updates the same edge.
- Flags: `frame_err` and `overrun` are registered and high for exactly 1 cycle.
- Baud tolerance: sampling at mid-bit tolerates ±3% combined baud error.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum {IDLE, START, DATA, STOP};
  - `OVERSAMPLE`=16, `DATA_BITS`=8, `START_MID`=8.
- Sub-module `uart_sync_fifo` (params WIDTH, DEPTH; FWFT; push/pop/full/empty/level).
- The FSM, tick generator and synchronizer stay in the top.

## Test plan
- Single frame 0xA5 at 115200 baud, `rx_ready`=1:
  - `rx_valid` rises at (2+1+152×54+1) cycles after the RX fall;
  - `rx_data`=0xA5, `rx_level` goes 0→1→0.
- Back-to-back bytes 0x00, 0xFF, 0x55 with no idle gap: three pushes in order and no flags.
- Glitch: RX low for 4×54 clocks, then high. The FSM returns to IDLE with no push and no flags.
- Framing error: 0x3C sent with the stop bit held 0, then the line is released high after 2 bit times:
  - one `frame_err` pulse and no push;
  - a following 0x12 frame is received correctly.
- Overrun: `rx_ready`=0, 9 frames 0x01..0x09 sent:
  - `rx_level`=8 and one `overrun` pulse on the 9th frame;
  - draining yields 0x01..0x08.
- Reset mid-frame: `RESETN` is pulsed low during DATA bit 3:
  - outputs return to reset values;
  - the remainder of that frame produces no push;
  - the next full frame 0xC3 is received.
